// File: rtl/fifo_pkg.sv
// Gray/binary helpers shared by the read- and write-side FIFO status controllers.
package fifo_pkg;

  localparam int MAX_ADDR_SIZE = 16;
  localparam int FN_W = MAX_ADDR_SIZE + 1;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin, input int width);
    logic [FN_W-1:0] g;
    g = (bin >> 1) ^ bin;
    for (int i = 0; i < FN_W; i++) begin
      if (i >= width) g[i] = 1'b0;
    end
    return g;
  endfunction

  // Bits above width are masked first so stray upper bits never leak into the prefix XOR.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray, input int width);
    logic [FN_W-1:0] gm;
    logic [FN_W-1:0] b;
    gm = gray;
    for (int i = 0; i < FN_W; i++) begin
      if (i >= width) gm[i] = 1'b0;
    end
    b = '0;
    for (int i = 0; i < FN_W; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/rd_status_ctrl.sv
// Read-domain pointer/status controller for the async FIFO: pointers, empty,
// fill level, almost-empty, read-valid strobe and sticky underflow.
module rd_status_ctrl
  import fifo_pkg::*;
#(
  parameter  int ADDR_SIZE = 4,
  localparam int PTR_W     = ADDR_SIZE + 1
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_inc,
  input  logic [PTR_W-1:0]     wr_q2_ptr,
  input  logic [PTR_W-1:0]     rd_ae_thresh,
  input  logic                 rd_underflow_clr,
  output logic [PTR_W-1:0]     rd_ptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [PTR_W-1:0]     rd_level,
  output logic                 rd_valid,
  output logic                 rd_underflow
);

  if (ADDR_SIZE < 2 || ADDR_SIZE > MAX_ADDR_SIZE) begin : g_bad_addr_size
    $error("rd_status_ctrl: ADDR_SIZE must be in 2..16");
  end

  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_level_q, rd_level_d;
  logic             rd_empty_q, rd_empty_d;
  logic             rd_ae_q, rd_ae_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_underflow_q, rd_underflow_d;
  logic [PTR_W-1:0] wr_bin;
  logic             accept;

  gray2bin #(.WIDTH(PTR_W)) u_wr_gray2bin (
    .gray (wr_q2_ptr),
    .bin  (wr_bin)
  );

  // Status is computed from the post-read pointer so a last-entry read raises empty on the same edge.
  always_comb begin
    accept         = rd_inc & ~rd_empty_q;
    rd_bin_d       = rd_bin_q + PTR_W'(accept);
    rd_ptr_d       = PTR_W'(bin2gray(FN_W'(rd_bin_d), PTR_W));
    rd_level_d     = wr_bin - rd_bin_d;
    rd_empty_d     = (rd_ptr_d == wr_q2_ptr);
    rd_ae_d        = (rd_level_d <= rd_ae_thresh);
    rd_valid_d     = accept;
    rd_underflow_d = (rd_inc & rd_empty_q) | (rd_underflow_q & ~rd_underflow_clr);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin_q       <= '0;
      rd_ptr_q       <= '0;
      rd_level_q     <= '0;
      rd_empty_q     <= 1'b1;
      rd_ae_q        <= 1'b1;
      rd_valid_q     <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_level_q     <= rd_level_d;
      rd_empty_q     <= rd_empty_d;
      rd_ae_q        <= rd_ae_d;
      rd_valid_q     <= rd_valid_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign rd_ptr          = rd_ptr_q;
  assign rd_addr         = rd_bin_q[ADDR_SIZE-1:0];
  assign rd_empty        = rd_empty_q;
  assign rd_almost_empty = rd_ae_q;
  assign rd_level        = rd_level_q;
  assign rd_valid        = rd_valid_q;
  assign rd_underflow    = rd_underflow_q;

endmodule
